// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch side of the 3-stage core.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the fetch debug statistics.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  // Sticks at all-ones so a long run never wraps back to a misleading small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !hold && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// PC and IF->EX register owner: redirects fetch on taken branches, inserts a squash
// bubble, and traps on misaligned targets.
module fetch_redirect_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = pipeline_pkg::NOP_INSTR,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_target,
  input  logic [31:0]       imem_rdata,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_ex,
  output logic [31:0]       instr_ex,
  output logic              valid_ex,
  output logic              flush,
  output logic              misalign,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  fetch_state_t    state, state_next;
  logic            redirect, aligned, accept;
  logic [XLEN-1:0] pc_next, pc_ex_next;
  logic [31:0]     instr_next;
  logic            valid_next, flush_next, misalign_next;

  // A bubble in EX carries no real branch, so its br_taken must not redirect.
  assign redirect = br_taken & valid_ex;
  assign aligned  = (br_target[1:0] == 2'b00);
  assign accept   = (state == RUN) && !stall && redirect && aligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (!stall && redirect) state_next = aligned ? FLUSH : TRAP;
      FLUSH:   if (!stall) state_next = RUN;
      TRAP:    state_next = TRAP;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_next       = pc;
    pc_ex_next    = pc_ex;
    instr_next    = instr_ex;
    valid_next    = valid_ex;
    flush_next    = flush;
    misalign_next = misalign;
    if (!stall) begin
      unique case (state)
        RUN: begin
          flush_next = 1'b0;
          if (redirect && aligned) begin
            pc_next    = br_target;
            pc_ex_next = pc;
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
            flush_next = 1'b1;
          end else if (redirect) begin
            instr_next    = NOP_INSTR;
            valid_next    = 1'b0;
            misalign_next = 1'b1;
          end else begin
            pc_next    = pc + XLEN'(PC_STEP);
            pc_ex_next = pc;
            instr_next = imem_rdata;
            valid_next = 1'b1;
          end
        end
        FLUSH: begin
          pc_next    = pc + XLEN'(PC_STEP);
          pc_ex_next = pc;
          instr_next = imem_rdata;
          valid_next = 1'b1;
          flush_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      pc_ex    <= '0;
      instr_ex <= NOP_INSTR;
      valid_ex <= 1'b0;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_next;
      pc_ex    <= pc_ex_next;
      instr_ex <= instr_next;
      valid_ex <= valid_next;
      flush    <= flush_next;
      misalign <= misalign_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .hold  (stall),
    .count (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .hold  (stall),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit; a narrow-counter twin shares the stimulus
// so counter saturation is reached in a few branches.
module tb_fetch_redirect_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_ex;
    logic [31:0] instr;
    logic        valid;
    logic        flush;
    logic        mis;
    logic [15:0] tcnt;
    logic [15:0] fcnt;
  } exp_t;

  logic        clk, rst, stall, br_taken;
  logic [31:0] br_target, imem_rdata;
  logic [31:0] pc, pc_ex, instr_ex;
  logic        valid_ex, flush, misalign;
  logic [15:0] taken_cnt, flush_cnt;
  logic [31:0] s_pc, s_pc_ex, s_instr_ex;
  logic        s_valid_ex, s_flush, s_misalign;
  logic [1:0]  s_taken_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [31:0] m_pc, m_pc_ex, m_instr;
  logic        m_valid, m_flush, m_mis;
  logic [15:0] m_tcnt, m_fcnt;
  int          m_state;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h0000_00A0 + (a >> 2);
  endfunction

  assign imem_rdata = imem(pc);

  fetch_redirect_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_rdata(imem_rdata), .pc(pc), .pc_ex(pc_ex), .instr_ex(instr_ex),
    .valid_ex(valid_ex), .flush(flush), .misalign(misalign),
    .taken_cnt(taken_cnt), .flush_cnt(flush_cnt)
  );

  fetch_redirect_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_rdata(imem_rdata), .pc(s_pc), .pc_ex(s_pc_ex), .instr_ex(s_instr_ex),
    .valid_ex(s_valid_ex), .flush(s_flush), .misalign(s_misalign),
    .taken_cnt(s_taken_cnt), .flush_cnt(s_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc = 32'h0; m_pc_ex = 32'h0; m_instr = 32'h13;
    m_valid = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
    m_tcnt = 16'h0; m_fcnt = 16'h0; m_state = 0;
  endtask

  task automatic modelAdvance();
    m_pc_ex = m_pc;
    m_instr = imem(m_pc);
    m_valid = 1'b1;
    m_pc    = m_pc + 32'd4;
  endtask

  // Reference behaviour: 0 = running, 1 = bubble in EX, 2 = trapped.
  task automatic modelStep(input logic st, input logic bt, input logic [31:0] tgt);
    logic take;
    take = bt && m_valid;
    if (m_state == 2 || st) begin
    end else if (m_state == 1) begin
      modelAdvance();
      m_flush = 1'b0;
      m_state = 0;
    end else if (take && tgt[1:0] == 2'b00) begin
      m_pc_ex = m_pc;
      m_pc    = tgt;
      m_instr = 32'h13;
      m_valid = 1'b0;
      m_flush = 1'b1;
      m_state = 1;
      if (m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
      if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
    end else if (take) begin
      m_instr = 32'h13;
      m_valid = 1'b0;
      m_mis   = 1'b1;
      m_state = 2;
    end else begin
      modelAdvance();
    end
  endtask

  task automatic compareAll(input exp_t e);
    checkOutput("pc", pc, e.pc);
    checkOutput("pc_ex", pc_ex, e.pc_ex);
    checkOutput("instr_ex", instr_ex, e.instr);
    checkOutput("valid_ex", {31'b0, valid_ex}, {31'b0, e.valid});
    checkOutput("flush", {31'b0, flush}, {31'b0, e.flush});
    checkOutput("misalign", {31'b0, misalign}, {31'b0, e.mis});
    checkOutput("taken_cnt", {16'b0, taken_cnt}, {16'b0, e.tcnt});
    checkOutput("flush_cnt", {16'b0, flush_cnt}, {16'b0, e.fcnt});
    checkOutput("sat_taken_cnt", {30'b0, s_taken_cnt}, (e.tcnt > 16'd3) ? 32'd3 : {16'b0, e.tcnt});
    checkOutput("sat_flush_cnt", {30'b0, s_flush_cnt}, (e.fcnt > 16'd3) ? 32'd3 : {16'b0, e.fcnt});
  endtask

  // Called at a falling edge: drive one cycle, predict, then compare just after the rise.
  task automatic applyStimulus(input logic st, input logic bt, input logic [31:0] tgt);
    exp_t e;
    stall = st; br_taken = bt; br_target = tgt;
    modelStep(st, bt, tgt);
    e.pc = m_pc; e.pc_ex = m_pc_ex; e.instr = m_instr; e.valid = m_valid;
    e.flush = m_flush; e.mis = m_mis; e.tcnt = m_tcnt; e.fcnt = m_fcnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL scoreboard_empty observed 0 expected 1");
    end else begin
      compareAll(sb.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic applyReset();
    exp_t e;
    rst = 1'b1;
    #2;
    modelReset();
    e.pc = m_pc; e.pc_ex = m_pc_ex; e.instr = m_instr; e.valid = m_valid;
    e.flush = m_flush; e.mis = m_mis; e.tcnt = m_tcnt; e.fcnt = m_fcnt;
    compareAll(e);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    @(negedge clk);
    applyReset();

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200);
    applyStimulus(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h0000_0040);
    applyStimulus(1'b0, 1'b1, 32'h0000_0040);
    applyStimulus(1'b0, 1'b0, 32'h0);

    applyStimulus(1'b0, 1'b1, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0300);
    applyStimulus(1'b0, 1'b0, 32'h0);

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_1000 + 32'(i) * 32'h40);
      applyStimulus(1'b0, 1'b0, 32'h0);
    end

    for (int i = 0; i < 40; i++)
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    $urandom() & 32'h0000_FFFC);

    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 10; i++)
      applyStimulus($urandom_range(0, 1) == 1, 1'b1, $urandom() & 32'h0000_FFFC);
    applyReset();

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0500);
    applyReset();
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
